sb_tx_arbiter: RTL

Round-robin arbiter that shares the single 64-bit sideband transmit serializer among `NUM_REQ` message sources (link-training FSM, register-access completions, error/status messages). The serializer has no backpressure output, so this block keeps a conservative model of its buffer occupancy through a credit counter and a drain timer, and never issues a packet the serializer cannot store. It sits directly in front of the sideband TX serializer in the logical PHY. Its outputs connect one-to-one to the serializer's data, valid and enable inputs.

---
 rtl/sb_tx_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter feeding the sideband TX serializer, with a credit/drain model of its buffer.
// Optional build macro SB_TX_ARB_STRICT_PRIO_EN: requester 0 gets strict priority over the rest.
module sb_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int TX_DEPTH      = 4,
    parameter int PACKET_CYCLES = 96
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [64*NUM_REQ-1:0]         req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [63:0]                   tx_data_o,
    output logic                          tx_valid_o,
    output logic                          tx_enable_o,
    output logic [$clog2(TX_DEPTH):0]     credits_o,
    output logic                          busy_o
);

    localparam int CW  = $clog2(TX_DEPTH) + 1;
    localparam int PW  = $clog2(NUM_REQ);
    localparam int PW1 = PW + 1;
    localparam int DW  = $clog2(PACKET_CYCLES);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ACTIVE   = 2'd1,
        FULL     = 2'd2
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   ptr_r;
    logic [CW-1:0]   credits_r;
    logic [DW-1:0]   drain_r;
    logic [63:0]     tx_data_r;
    logic            tx_valid_r;
    logic            tx_enable_r;

    logic [NUM_REQ-1:0] grant_s;
    logic [NUM_REQ-1:0] cand_s;
    logic [PW-1:0]      win_s;
    logic [PW-1:0]      idx_s;
    logic               found_s;
    logic [63:0]        sel_data_s;
    logic               accept_s;
    logic               busy_s;
    logic               ret_s;
    logic [CW-1:0]      credits_nxt_s;

    // Index base+off modulo NUM_REQ, both operands already below NUM_REQ.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input logic [PW-1:0] off);
        logic [PW:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= PW1'(NUM_REQ)) begin
            s = s - PW1'(NUM_REQ);
        end else begin
            s = s;
        end
        return s[PW-1:0];
    endfunction

    // Winner selection: first valid candidate at or after the pointer, only while grants are allowed.
    always_comb begin
        grant_s = '0;
        win_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        cand_s  = req_valid_i;
`ifdef SB_TX_ARB_STRICT_PRIO_EN
        cand_s[0] = 1'b0;
`endif
        if (state_r == ACTIVE && enable_i && credits_r != '0) begin
`ifdef SB_TX_ARB_STRICT_PRIO_EN
            if (req_valid_i[0]) begin
                grant_s[0] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = 1'b0;
            end
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                idx_s = rr_idx(ptr_r, PW'(i));
                if (!found_s && cand_s[idx_s]) begin
                    grant_s[idx_s] = 1'b1;
                    win_s          = idx_s;
                    found_s        = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            grant_s = '0;
        end
        sel_data_s = req_data_i[64*win_s +: 64];
    end

    assign accept_s = |grant_s;
    assign busy_s   = (credits_r != CW'(TX_DEPTH));
    assign ret_s    = busy_s && (drain_r == DW'(PACKET_CYCLES - 1));

    // Credit bookkeeping: an accept and a return in the same cycle cancel out.
    always_comb begin
        case ({accept_s, ret_s})
            2'b10:   credits_nxt_s = credits_r - CW'(1);
            2'b01:   credits_nxt_s = credits_r + CW'(1);
            default: credits_nxt_s = credits_r;
        endcase
    end

    // FSM, pointer, drain timer and registered serializer outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= DISABLED;
            ptr_r       <= '0;
            credits_r   <= CW'(TX_DEPTH);
            drain_r     <= '0;
            tx_data_r   <= 64'd0;
            tx_valid_r  <= 1'b0;
            tx_enable_r <= 1'b0;
        end else begin
            tx_enable_r <= enable_i;
            tx_valid_r  <= accept_s;
            credits_r   <= credits_nxt_s;
            if (accept_s) begin
                tx_data_r <= sel_data_s;
`ifdef SB_TX_ARB_STRICT_PRIO_EN
                if (!grant_s[0]) begin
                    ptr_r <= rr_idx(win_s, PW'(1));
                end
`else
                ptr_r <= rr_idx(win_s, PW'(1));
`endif
            end
            // Timer restarts on the first packet into an empty buffer, wraps on every return.
            if (accept_s && !busy_s) begin
                drain_r <= '0;
            end else if (ret_s) begin
                drain_r <= '0;
            end else if (busy_s) begin
                drain_r <= drain_r + DW'(1);
            end
            case (state_r)
                DISABLED: begin
                    if (enable_i) begin
                        state_r <= (credits_nxt_s != '0) ? ACTIVE : FULL;
                    end
                end
                ACTIVE: begin
                    if (!enable_i) begin
                        state_r <= DISABLED;
                    end else if (credits_nxt_s == '0) begin
                        state_r <= FULL;
                    end
                end
                FULL: begin
                    if (!enable_i) begin
                        state_r <= DISABLED;
                    end else if (ret_s) begin
                        state_r <= ACTIVE;
                    end
                end
                default: state_r <= DISABLED;
            endcase
        end
    end

    assign req_ready_o = grant_s;
    assign tx_data_o   = tx_data_r;
    assign tx_valid_o  = tx_valid_r;
    assign tx_enable_o = tx_enable_r;
    assign credits_o   = credits_r;
    assign busy_o      = busy_s;

endmodule
